// File: rtl/axis_arb_pkg.sv
// rtl/axis_arb_pkg.sv - shared arbiter state type and round-robin priority search
package axis_arb_pkg;

  typedef enum logic [0:0] {ARB_IDLE, ARB_LOCKED} arb_state_t;

  localparam int unsigned RrMaxPorts = 32;
  localparam int unsigned RrIdxW     = 5;

  typedef struct packed {
    logic              found;
    logic [RrIdxW-1:0] idx;
  } rr_pick_t;

  // Walks offsets from far to near so the candidate closest to ptr is written last and wins.
  function automatic rr_pick_t rr_pick(input logic [RrMaxPorts-1:0] req,
                                       input int unsigned n,
                                       input int unsigned ptr);
    rr_pick_t    res;
    int unsigned cand;
    res = '0;
    for (int off = RrMaxPorts - 1; off >= 0; off--) begin
      cand = ptr + unsigned'(off);
      if (cand >= n) cand = cand - n;
      if ((unsigned'(off) < n) && req[cand[RrIdxW-1:0]]) begin
        res.found = 1'b1;
        res.idx   = cand[RrIdxW-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/axis_rr_pick.sv
// rtl/axis_rr_pick.sv - combinational round-robin pick: first requester at or after ptr, wrapping
module axis_rr_pick
  import axis_arb_pkg::*;
#(
  parameter int unsigned NumPorts = 4,
  parameter int unsigned IdxWidth = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
  input  logic [NumPorts-1:0] req_i,
  input  logic [IdxWidth-1:0] ptr_i,
  output logic                found_o,
  output logic [IdxWidth-1:0] idx_o
);

  logic [RrMaxPorts-1:0] req_ext;
  rr_pick_t              pick;

  always_comb begin
    req_ext                 = '0;
    req_ext[NumPorts-1:0]   = req_i;
    pick                    = rr_pick(req_ext, NumPorts, 32'(ptr_i));
    found_o                 = pick.found;
    idx_o                   = IdxWidth'(pick.idx);
  end

endmodule

// File: rtl/axis_rr_arbiter.sv
// rtl/axis_rr_arbiter.sv - packet-locking round-robin arbiter merging NumPorts streams into one registered sink
module axis_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter int unsigned NumPorts   = 4,
  parameter int unsigned DataWidth  = 16,
  parameter bit          LockOnLast = 1'b1,
  parameter int unsigned IdxWidth   = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumPorts*DataWidth-1:0] s_data_i,
  input  logic [NumPorts-1:0]           s_last_i,
  input  logic [NumPorts-1:0]           s_valid_i,
  output logic [NumPorts-1:0]           s_ready_o,
  output logic [DataWidth-1:0]          m_data_o,
  output logic                          m_last_o,
  output logic [IdxWidth-1:0]           m_src_o,
  output logic                          m_valid_o,
  input  logic                          m_ready_i,
  output logic                          busy_o
);

  arb_state_t           state_q, state_d;
  logic [IdxWidth-1:0]  grant_q, grant_d;
  logic [IdxWidth-1:0]  ptr_q, ptr_d;
  logic [IdxWidth-1:0]  pick_idx;
  logic                 pick_found;

  logic                 out_rdy;
  logic                 sel_valid, sel_last, xfer;
  logic [DataWidth-1:0] sel_data;

  logic                 oval_q, olast_q;
  logic [DataWidth-1:0] odata_q;
  logic [IdxWidth-1:0]  osrc_q;

  axis_rr_pick #(
    .NumPorts (NumPorts),
    .IdxWidth (IdxWidth)
  ) u_pick (
    .req_i   (s_valid_i),
    .ptr_i   (ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  assign out_rdy = !oval_q || m_ready_i;

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int k = 0; k < NumPorts; k++) begin
      if (grant_q == IdxWidth'(k)) begin
        sel_valid = s_valid_i[k];
        sel_last  = s_last_i[k];
        sel_data  = s_data_i[k*DataWidth +: DataWidth];
      end
    end
  end

  assign xfer = (state_q == ARB_LOCKED) && sel_valid && out_rdy;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    s_ready_o = '0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = ARB_LOCKED;
        end
      end
      ARB_LOCKED: begin
        // Ready depends only on the grant register and out_rdy, never on s_valid_i.
        for (int k = 0; k < NumPorts; k++) begin
          s_ready_o[k] = (grant_q == IdxWidth'(k)) && out_rdy;
        end
        if (xfer && (sel_last || !LockOnLast)) begin
          ptr_d   = (grant_q == IdxWidth'(NumPorts - 1)) ? '0 : grant_q + IdxWidth'(1);
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  // Output register loads whenever it is empty or being drained; bubbles load oval=0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      oval_q  <= 1'b0;
      odata_q <= '0;
      olast_q <= 1'b0;
      osrc_q  <= '0;
    end else if (out_rdy) begin
      oval_q  <= (state_q == ARB_LOCKED) && sel_valid;
      odata_q <= sel_data;
      olast_q <= sel_last;
      osrc_q  <= grant_q;
    end
  end

  assign m_valid_o = oval_q;
  assign m_data_o  = odata_q;
  assign m_last_o  = olast_q;
  assign m_src_o   = osrc_q;
  assign busy_o    = (state_q == ARB_LOCKED);

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// tb/tb_axis_rr_arbiter.sv - directed bench with behavioural arbiter model and per-cycle compare
module tb_axis_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;

  logic            clk_i   = 1'b0;
  logic            rst_ni  = 1'b0;
  logic [N*DW-1:0] s_data  = '0;
  logic [N-1:0]    s_last  = '0;
  logic [N-1:0]    s_valid = '0;
  logic [N-1:0]    s_ready;
  logic [DW-1:0]   m_data;
  logic            m_last;
  logic [1:0]      m_src;
  logic            m_valid;
  logic            m_ready = 1'b1;
  logic            busy;

  logic [2*DW-1:0] b_s_data  = {16'h00B1, 16'h00B0};
  logic [1:0]      b_s_last  = '0;
  logic [1:0]      b_s_valid = '0;
  logic [1:0]      b_s_ready;
  logic [DW-1:0]   b_m_data;
  logic            b_m_last, b_m_src, b_m_valid, b_busy;
  logic            b_m_ready = 1'b1;

  always #5 clk_i = ~clk_i;

  axis_rr_arbiter #(.NumPorts(N), .DataWidth(DW), .LockOnLast(1'b1)) u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .s_data_i(s_data), .s_last_i(s_last),
    .s_valid_i(s_valid), .s_ready_o(s_ready), .m_data_o(m_data), .m_last_o(m_last),
    .m_src_o(m_src), .m_valid_o(m_valid), .m_ready_i(m_ready), .busy_o(busy));

  axis_rr_arbiter #(.NumPorts(2), .DataWidth(DW), .LockOnLast(1'b0)) u_dut_beat (
    .clk_i(clk_i), .rst_ni(rst_ni), .s_data_i(b_s_data), .s_last_i(b_s_last),
    .s_valid_i(b_s_valid), .s_ready_o(b_s_ready), .m_data_o(b_m_data), .m_last_o(b_m_last),
    .m_src_o(b_m_src), .m_valid_o(b_m_valid), .m_ready_i(b_m_ready), .busy_o(b_busy));

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;
  bit done   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Stimulus: per-port beat queues {last, data}; head is presented while the queue is non-empty.
  logic [16:0] srcq [N][$];
  logic [N-1:0] hs = '0;
  int mr_mode = 0;
  int mr_idx  = 0;
  bit mr_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic [18:0] log_q [$];

  always @(posedge clk_i) begin
    #1;
    for (int k = 0; k < N; k++)
      if (hs[k] && srcq[k].size() > 0) void'(srcq[k].pop_front());
    for (int k = 0; k < N; k++) begin
      if (srcq[k].size() > 0) begin
        s_valid[k]           = 1'b1;
        s_data[k*DW +: DW]   = srcq[k][0][15:0];
        s_last[k]            = srcq[k][0][16];
      end else begin
        s_valid[k]           = 1'b0;
        s_data[k*DW +: DW]   = '0;
        s_last[k]            = 1'b0;
      end
    end
    case (mr_mode)
      0:       m_ready = 1'b1;
      1:       begin m_ready = mr_pat[mr_idx % 4]; mr_idx++; end
      default: m_ready = 1'b0;
    endcase
  end

  // Model: owner=-1 means no grant; prio is the index searched first at the next free slot.
  int          mo_owner = -1;
  int          mo_prio  = 0;
  logic        mo_val   = 1'b0;
  logic [15:0] mo_data  = '0;
  logic        mo_last  = 1'b0;
  int          mo_src   = 0;

  function automatic int first_req(input logic [N-1:0] req, input int from);
    for (int k = 0; k < N; k++)
      if (req[2'((from + k) % N)]) return (from + k) % N;
    return -1;
  endfunction

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mo_owner <= -1;
      mo_prio  <= 0;
      mo_val   <= 1'b0;
      mo_data  <= '0;
      mo_last  <= 1'b0;
      mo_src   <= 0;
    end else begin
      if (!mo_val || m_ready) begin
        mo_val <= (mo_owner >= 0) && s_valid[2'(mo_owner)];
        if (mo_owner >= 0) begin
          mo_data <= s_data[6'(mo_owner * DW) +: DW];
          mo_last <= s_last[2'(mo_owner)];
          mo_src  <= mo_owner;
        end
      end
      if (mo_owner < 0) begin
        if (first_req(s_valid, mo_prio) >= 0) mo_owner <= first_req(s_valid, mo_prio);
      end else if ((!mo_val || m_ready) && s_valid[2'(mo_owner)] && s_last[2'(mo_owner)]) begin
        mo_prio  <= (mo_owner + 1) % N;
        mo_owner <= -1;
      end
    end
  end

  function automatic logic [N-1:0] exp_ready();
    if (mo_owner >= 0 && (!mo_val || m_ready)) return 4'(1 << mo_owner);
    return '0;
  endfunction

  always @(negedge clk_i) begin
    hs = s_ready & s_valid;
    if (m_valid && m_ready) log_q.push_back({m_last, m_src, m_data});
    if (chk_en) begin
      chk("m_valid", 32'(m_valid), 32'(mo_val));
      if (mo_val) begin
        chk("m_data", 32'(m_data), 32'(mo_data));
        chk("m_last", 32'(m_last), 32'(mo_last));
        chk("m_src", 32'(m_src), 32'(mo_src));
      end
      chk("busy", 32'(busy), 32'(mo_owner >= 0));
      chk("s_ready", 32'(s_ready), 32'(exp_ready()));
    end
  end

  task automatic wait_log(input int n, input string name);
    int budget = 200;
    while (log_q.size() < n && budget > 0) begin
      @(negedge clk_i);
      budget--;
    end
    chk({name, "_count"}, 32'(log_q.size() >= n), 32'd1);
  endtask

  task automatic chk_beat(input string name, input int i, input logic [15:0] d,
                          input logic [1:0] s, input logic l);
    chk($sformatf("%s_beat%0d", name, i),
        (i < log_q.size()) ? 32'(log_q[i]) : 32'hFFFF_FFFF, 32'({l, s, d}));
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    #2 rst_ni = 1'b0;
    for (int k = 0; k < N; k++) srcq[k].delete();
    mr_mode = 0;
    @(posedge clk_i);
    @(posedge clk_i);
    #2 rst_ni = 1'b1;
    log_q.delete();
    @(negedge clk_i);
  endtask

  initial begin
    int sv, mv;
    logic bv [12];
    logic bs [12];
    logic [15:0] bd [12];

    @(negedge clk_i);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_m_last", 32'(m_last), 32'd0);
    chk("rst_m_src", 32'(m_src), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge clk_i);
    #2 rst_ni = 1'b1;
    chk_en = 1'b1;
    @(negedge clk_i);

    // Single packet on port 2
    srcq[2].push_back({1'b0, 16'h0011});
    srcq[2].push_back({1'b0, 16'h0022});
    srcq[2].push_back({1'b1, 16'h0033});
    sv = -1;
    mv = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      if (s_valid != 0 && sv < 0) sv = i;
      if (m_valid && mv < 0) mv = i;
    end
    chk("single_latency", 32'(mv - sv), 32'd2);
    wait_log(3, "single");
    chk_beat("single", 0, 16'h0011, 2'd2, 1'b0);
    chk_beat("single", 1, 16'h0022, 2'd2, 1'b0);
    chk_beat("single", 2, 16'h0033, 2'd2, 1'b1);
    repeat (3) @(negedge clk_i);
    chk("single_busy_end", 32'(busy), 32'd0);

    // Contention among ports 0, 1, 3; port 0 re-requests
    do_reset();
    srcq[0].push_back({1'b0, 16'h0100});
    srcq[0].push_back({1'b1, 16'h0101});
    srcq[0].push_back({1'b0, 16'h0102});
    srcq[0].push_back({1'b1, 16'h0103});
    srcq[1].push_back({1'b0, 16'h0110});
    srcq[1].push_back({1'b1, 16'h0111});
    srcq[3].push_back({1'b0, 16'h0130});
    srcq[3].push_back({1'b1, 16'h0131});
    wait_log(8, "cont");
    chk_beat("cont", 0, 16'h0100, 2'd0, 1'b0);
    chk_beat("cont", 1, 16'h0101, 2'd0, 1'b1);
    chk_beat("cont", 2, 16'h0110, 2'd1, 1'b0);
    chk_beat("cont", 3, 16'h0111, 2'd1, 1'b1);
    chk_beat("cont", 4, 16'h0130, 2'd3, 1'b0);
    chk_beat("cont", 5, 16'h0131, 2'd3, 1'b1);
    chk_beat("cont", 6, 16'h0102, 2'd0, 1'b0);
    chk_beat("cont", 7, 16'h0103, 2'd0, 1'b1);
    repeat (3) @(negedge clk_i);

    // Backpressure pattern 1,0,0,1 over a 4-beat packet
    do_reset();
    mr_idx  = 0;
    mr_mode = 1;
    for (int b = 0; b < 4; b++) srcq[1].push_back({b == 3, 16'h01A0 + 16'(b)});
    wait_log(4, "bp");
    for (int b = 0; b < 4; b++) chk_beat("bp", b, 16'h01A0 + 16'(b), 2'd1, b == 3);
    repeat (4) @(negedge clk_i);
    chk("bp_no_dup", 32'(log_q.size()), 32'd4);
    mr_mode = 0;

    // Last beat presented under a stall; ptr must not advance until it transfers
    do_reset();
    mr_mode = 2;
    srcq[2].push_back({1'b0, 16'h02A0});
    srcq[2].push_back({1'b1, 16'h02A1});
    repeat (3) @(negedge clk_i);
    srcq[0].push_back({1'b1, 16'h00C0});
    srcq[3].push_back({1'b1, 16'h03B0});
    repeat (4) @(negedge clk_i);
    chk("stall_busy", 32'(busy), 32'd1);
    chk("stall_s_ready", 32'(s_ready), 32'd0);
    chk("stall_m_valid", 32'(m_valid), 32'd1);
    chk("stall_m_data", 32'(m_data), 32'h02A0);
    mr_mode = 0;
    wait_log(4, "stall");
    chk_beat("stall", 0, 16'h02A0, 2'd2, 1'b0);
    chk_beat("stall", 1, 16'h02A1, 2'd2, 1'b1);
    chk_beat("stall", 2, 16'h03B0, 2'd3, 1'b1);
    chk_beat("stall", 3, 16'h00C0, 2'd0, 1'b1);
    repeat (3) @(negedge clk_i);

    // Reset in the middle of a packet
    do_reset();
    for (int b = 0; b < 4; b++) srcq[1].push_back({b == 3, 16'h01E0 + 16'(b)});
    wait_log(2, "midrst_pre");
    #2 rst_ni = 1'b0;
    #1;
    chk("midrst_m_valid", 32'(m_valid), 32'd0);
    chk("midrst_s_ready", 32'(s_ready), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_m_data", 32'(m_data), 32'd0);
    for (int k = 0; k < N; k++) srcq[k].delete();
    @(posedge clk_i);
    @(posedge clk_i);
    #2 rst_ni = 1'b1;
    log_q.delete();
    @(negedge clk_i);
    srcq[0].push_back({1'b1, 16'h00D0});
    srcq[1].push_back({1'b1, 16'h01D0});
    srcq[2].push_back({1'b1, 16'h02D0});
    wait_log(3, "midrst");
    chk_beat("midrst", 0, 16'h00D0, 2'd0, 1'b1);
    chk_beat("midrst", 1, 16'h01D0, 2'd1, 1'b1);
    chk_beat("midrst", 2, 16'h02D0, 2'd2, 1'b1);

    // Beat-level round robin on the LockOnLast=0 instance
    @(posedge clk_i);
    #1 b_s_valid = 2'b11;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_i);
      bv[i] = b_m_valid;
      bs[i] = b_m_src;
      bd[i] = b_m_data;
      chk("lol_ready_onehot", 32'($countones(b_s_ready) <= 1), 32'd1);
    end
    chk("lol_pre_valid", 32'(bv[1]), 32'd0);
    chk("lol_busy", 32'(b_busy), 32'(b_busy));
    chk("lol_last", 32'(b_m_last), 32'd0);
    for (int j = 0; j < 8; j++) begin
      chk($sformatf("lol_valid%0d", j), 32'(bv[2+j]), 32'(j % 2 == 0));
      if (j % 2 == 0) begin
        chk($sformatf("lol_src%0d", j), 32'(bs[2+j]), 32'((j / 2) % 2));
        chk($sformatf("lol_data%0d", j), 32'(bd[2+j]), ((j / 2) % 2) ? 32'h00B1 : 32'h00B0);
      end
    end
    b_s_valid = 2'b00;
    repeat (3) @(negedge clk_i);

    done = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL watchdog: got timeout want completion");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

endmodule
